pcie_c2h_dsc_ring: RTL and testbench
====================================

PCIE_C2H_DSC_RING -- requirements
Module: pcie_c2h_dsc_ring

Interface
REQ-001 Parameter NUM_CH, default 1: number of independent C2H channels, 1..4.
REQ-002 Parameter NUM_BUFS, default 16: host buffers per channel; power of two, 2..256.
REQ-003 Parameter BUF_BYTES, default 4096: bytes per host buffer; power of two, 64..2^27.
REQ-004 Parameter BASE_ADDR, default 64'h1_0000_0000: host address of channel 0, buffer 0.
REQ-005 Parameter CTL_VALUE, default 16'h0: value driven on every descriptor ctl field.
REQ-006 axi_aclk  in  1  sole clock; all logic is rising-edge.
REQ-007 axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-008 enable  in  NUM_CH  per-channel enable for descriptor issue.
REQ-009 dsc_byp_ready  in  NUM_CH  per-channel engine ready.
REQ-010 dsc_byp_load  out  NUM_CH  per-channel descriptor load strobe.
REQ-011 dsc_byp_dst_addr  out  64*NUM_CH  destination host address; channel c in bits [64c+63:64c].
REQ-012 dsc_byp_src_addr  out  64*NUM_CH  source address; constant 0.
REQ-013 dsc_byp_len  out  28*NUM_CH  transfer length in bytes.
REQ-014 dsc_byp_ctl  out  16*NUM_CH  descriptor control; equals CTL_VALUE.
REQ-015 credit_ret  in  NUM_CH  one-cycle pulse; host has freed one buffer on that channel.
REQ-016 credits  out  9*NUM_CH  available buffers per channel.
REQ-017 wrap_cnt  out  16*NUM_CH  ring wrap count per channel.
REQ-018 credit_err  out  NUM_CH  sticky error: credit returned while the channel's ring was full.

Function
REQ-019 Each channel SHALL have a separate FSM, index, credit counter and output register set; channels SHALL NOT interact.
REQ-020 States per channel: IDLE, ARM, LOAD.
REQ-021 IDLE -> ARM when enable[c]=1.
REQ-022 ARM -> LOAD when enable[c]=1, dsc_byp_ready[c]=1 and credits[c]>0; ARM -> IDLE when enable[c]=0.
REQ-023 LOAD SHALL last exactly one cycle with dsc_byp_load[c]=1, then go to ARM; successive loads on a channel are at least 2 cycles apart.
REQ-024 Outputs SHALL be registered: dsc_byp_load[c] is high in the cycle after the ARM condition is sampled true, and is high only in LOAD.
REQ-025 dst_addr[c] SHALL be BASE_ADDR + (c*NUM_BUFS + idx[c])*BUF_BYTES, computed in 64 bits, and SHALL hold stable throughout LOAD.
REQ-026 dsc_byp_len[c] SHALL be BUF_BYTES[27:0].
REQ-027 On leaving LOAD: idx[c] increments modulo NUM_BUFS. When idx wraps from NUM_BUFS-1 to 0, wrap_cnt[c] increments modulo 2^16.
REQ-028 credits[c]: decrement by 1 on LOAD; increment by 1 on credit_ret[c]; unchanged when both occur in the same cycle.
REQ-029 If credit_ret[c] arrives with credits[c]=NUM_BUFS and no LOAD in that cycle, the credit SHALL be ignored and credit_err[c] set; credit_err[c] clears only on reset.
REQ-030 If credits[c]=0, the channel SHALL stall in ARM without asserting load, regardless of ready.
REQ-031 If enable[c] falls during LOAD, that load SHALL complete; the FSM then passes through ARM to IDLE. idx and credits are preserved, and issue resumes at the same idx when re-enabled.
REQ-032 dsc_byp_ready falling during LOAD SHALL NOT truncate or repeat the strobe.

Reset
REQ-033 On axi_aresetn=0 (asynchronous): FSM=IDLE, dsc_byp_load=0, idx=0, credits=NUM_BUFS, wrap_cnt=0, credit_err=0, dst_addr=BASE_ADDR + c*NUM_BUFS*BUF_BYTES, src_addr=0, len=BUF_BYTES, ctl=CTL_VALUE.
REQ-034 Reset assertion mid-LOAD SHALL drop dsc_byp_load in the same cycle. Deassertion is synchronised to axi_aclk, and the first load follows no sooner than 2 cycles after deassertion.

Verification
REQ-035 Defaults; enable=1; ready held high; no credits returned -> exactly 16 loads with dst 0x1_0000_0000, 0x1_0000_1000, ... 0x1_0000_F000, then stall with credits=0.
REQ-036 From stall, pulse credit_ret 3 times -> exactly 3 more loads with dst 0x1_0000_0000, 0x1_0000_1000, 0x1_0000_2000; wrap_cnt=1.
REQ-037 credit_ret in the same cycle as a LOAD -> credits unchanged; a credit_ret at credits=16 -> credit_err=1 and credits stays 16.
REQ-038 NUM_CH=2, NUM_BUFS=4, ready toggled randomly on channel 1 only -> channel 0 issues 0x1_0000_0000.. at full rate; channel 1 dst starts at 0x1_0000_4000; each load lasts one cycle.
REQ-039 Drop enable during LOAD, then restore it 10 cycles later -> the in-flight load completes and the next load uses idx+1.
REQ-040 Assert reset mid-LOAD -> load=0 immediately; after release, idx=0, credits=NUM_BUFS, and the first load occurs no sooner than 2 cycles after release.

Source files
------------

// File: rtl/pcie_c2h_dsc_ring.sv
// C2H descriptor-bypass ring: each channel issues fixed-size host buffers in ring order,
// gated by enable, engine ready and per-channel buffer credits.
module pcie_c2h_dsc_ring #(
    parameter int unsigned NUM_CH    = 1,
    parameter int unsigned NUM_BUFS  = 16,
    parameter int unsigned BUF_BYTES = 4096,
    parameter logic [63:0] BASE_ADDR = 64'h1_0000_0000,
    parameter logic [15:0] CTL_VALUE = 16'h0
) (
    input  logic                 axi_aclk,
    input  logic                 axi_aresetn,
    input  logic [NUM_CH-1:0]    enable,
    input  logic [NUM_CH-1:0]    dsc_byp_ready,
    output logic [NUM_CH-1:0]    dsc_byp_load,
    output logic [64*NUM_CH-1:0] dsc_byp_dst_addr,
    output logic [64*NUM_CH-1:0] dsc_byp_src_addr,
    output logic [28*NUM_CH-1:0] dsc_byp_len,
    output logic [16*NUM_CH-1:0] dsc_byp_ctl,
    input  logic [NUM_CH-1:0]    credit_ret,
    output logic [9*NUM_CH-1:0]  credits,
    output logic [16*NUM_CH-1:0] wrap_cnt,
    output logic [NUM_CH-1:0]    credit_err
);
    localparam int unsigned IdxW     = $clog2(NUM_BUFS);
    localparam int unsigned BufShift = $clog2(BUF_BYTES);
    localparam logic [8:0]  CredMax  = 9'(NUM_BUFS);
    localparam logic [27:0] LenValue = 28'(BUF_BYTES);

    typedef enum logic [1:0] {StIdle, StArm, StLoad} state_e;

    // Reset asserts asynchronously but releases only after two clean clock edges.
    logic [1:0] rst_sync_q;
    logic       rst_n;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [63:0] ChFirstBuf = 64'(c) * 64'(NUM_BUFS);
        localparam logic [63:0] ChAddr     = BASE_ADDR + (ChFirstBuf << BufShift);

        state_e          state_q, state_d;
        logic            load_q, load_d;
        logic [IdxW-1:0] idx_q, idx_d;
        logic [8:0]      cred_q, cred_d;
        logic [15:0]     wrap_q, wrap_d;
        logic            err_q, err_d;
        logic [63:0]     dst_q, dst_d;

        always_comb begin
            state_d = state_q;
            load_d  = 1'b0;
            idx_d   = idx_q;
            wrap_d  = wrap_q;
            unique case (state_q)
                StIdle: begin
                    if (enable[c]) begin
                        state_d = StArm;
                    end
                end
                StArm: begin
                    if (!enable[c]) begin
                        state_d = StIdle;
                    end else if (dsc_byp_ready[c] && (cred_q != 9'd0)) begin
                        state_d = StLoad;
                        load_d  = 1'b1;
                    end
                end
                StLoad: begin
                    // A started load always completes; enable is re-checked in ARM.
                    state_d = StArm;
                    idx_d   = idx_q + 1'b1;
                    if (&idx_q) begin
                        wrap_d = wrap_q + 16'd1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Address tracks the index register so it is already valid when LOAD begins.
        assign dst_d = BASE_ADDR + ((ChFirstBuf + 64'(idx_d)) << BufShift);

        always_comb begin
            cred_d = cred_q;
            err_d  = err_q;
            if (credit_ret[c] && !load_q) begin
                if (cred_q == CredMax) begin
                    err_d = 1'b1;
                end else begin
                    cred_d = cred_q + 9'd1;
                end
            end else if (!credit_ret[c] && load_q) begin
                cred_d = cred_q - 9'd1;
            end
        end

        always_ff @(posedge axi_aclk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= StIdle;
                load_q  <= 1'b0;
                idx_q   <= '0;
                cred_q  <= CredMax;
                wrap_q  <= 16'd0;
                err_q   <= 1'b0;
                dst_q   <= ChAddr;
            end else begin
                state_q <= state_d;
                load_q  <= load_d;
                idx_q   <= idx_d;
                cred_q  <= cred_d;
                wrap_q  <= wrap_d;
                err_q   <= err_d;
                dst_q   <= dst_d;
            end
        end

        assign dsc_byp_load[c]               = load_q;
        assign dsc_byp_dst_addr[64*c +: 64]  = dst_q;
        assign dsc_byp_src_addr[64*c +: 64]  = 64'd0;
        assign dsc_byp_len[28*c +: 28]       = LenValue;
        assign dsc_byp_ctl[16*c +: 16]       = CTL_VALUE;
        assign credits[9*c +: 9]             = cred_q;
        assign wrap_cnt[16*c +: 16]          = wrap_q;
        assign credit_err[c]                 = err_q;
    end

endmodule

// File: tb/tb_pcie_c2h_dsc_ring.sv
// Bench for pcie_c2h_dsc_ring: a default single-channel ring and a 2-channel, 4-buffer ring,
// checked each cycle against a behavioural ring model plus directed literal expectations.
module tb_pcie_c2h_dsc_ring;
    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic        en_a, rdy_a, ret_a, load_a, err_a;
    logic [63:0] dst_a, src_a;
    logic [27:0] len_a;
    logic [15:0] ctl_a, wrap_a;
    logic [8:0]  cred_a;

    logic [1:0]   en_b, rdy_b, ret_b, load_b, err_b;
    logic [127:0] dst_b, src_b;
    logic [55:0]  len_b;
    logic [31:0]  ctl_b, wrap_b;
    logic [17:0]  cred_b;

    pcie_c2h_dsc_ring u_dut_a (
        .axi_aclk        (clk),
        .axi_aresetn     (rstn),
        .enable          (en_a),
        .dsc_byp_ready   (rdy_a),
        .dsc_byp_load    (load_a),
        .dsc_byp_dst_addr(dst_a),
        .dsc_byp_src_addr(src_a),
        .dsc_byp_len     (len_a),
        .dsc_byp_ctl     (ctl_a),
        .credit_ret      (ret_a),
        .credits         (cred_a),
        .wrap_cnt        (wrap_a),
        .credit_err      (err_a)
    );

    pcie_c2h_dsc_ring #(
        .NUM_CH   (2),
        .NUM_BUFS (4),
        .CTL_VALUE(16'h5A3C)
    ) u_dut_b (
        .axi_aclk        (clk),
        .axi_aresetn     (rstn),
        .enable          (en_b),
        .dsc_byp_ready   (rdy_b),
        .dsc_byp_load    (load_b),
        .dsc_byp_dst_addr(dst_b),
        .dsc_byp_src_addr(src_b),
        .dsc_byp_len     (len_b),
        .dsc_byp_ctl     (ctl_b),
        .credit_ret      (ret_b),
        .credits         (cred_b),
        .wrap_cnt        (wrap_b),
        .credit_err      (err_b)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 40)
                $display("FAIL %s at t=%0t: got 0x%0h, required 0x%0h", name, $time, act, exp);
        end
    endtask

    // Ring model; index g: 0 = A ch0, 1 = B ch0, 2 = B ch1.
    int nb_g[3] = '{16, 4, 4};
    int ch_g[3] = '{0, 0, 1};
    bit m_armed[3];
    bit m_load[3];
    bit m_err[3];
    int m_idx[3];
    int m_cred[3];
    int m_wrap[3];
    int sync_cnt = 0;
    int cyc = 0;
    bit chk_on = 0;

    task automatic model_reset(int g);
        m_armed[g] = 0;
        m_load[g]  = 0;
        m_err[g]   = 0;
        m_idx[g]   = 0;
        m_cred[g]  = nb_g[g];
        m_wrap[g]  = 0;
    endtask

    task automatic model_step(int g, bit en, bit rdy, bit ret);
        int cred_old;
        bit was_load;
        cred_old = m_cred[g];
        was_load = m_load[g];
        if (ret && !was_load && cred_old == nb_g[g]) m_err[g] = 1;
        else m_cred[g] = cred_old + int'(ret) - int'(was_load);
        if (was_load) begin
            m_load[g]  = 0;
            m_armed[g] = 1;
            m_idx[g]   = (m_idx[g] + 1) % nb_g[g];
            if (m_idx[g] == 0) m_wrap[g] = (m_wrap[g] + 1) % 65536;
        end else if (m_armed[g]) begin
            if (!en) m_armed[g] = 0;
            else if (rdy && cred_old > 0) begin
                m_load[g]  = 1;
                m_armed[g] = 0;
            end
        end else if (en) begin
            m_armed[g] = 1;
        end
    endtask

    function automatic logic [2:0] get_in(int g);
        case (g)
            0:       return {en_a, rdy_a, ret_a};
            1:       return {en_b[0], rdy_b[0], ret_b[0]};
            default: return {en_b[1], rdy_b[1], ret_b[1]};
        endcase
    endfunction

    function automatic logic [63:0] exp_dst(int g);
        return 64'h1_0000_0000 + 64'((ch_g[g] * nb_g[g] + m_idx[g]) * 4096);
    endfunction

    task automatic get_out(int g, output logic ld, output logic [63:0] dst,
                           output logic [8:0] cr, output logic [15:0] wr, output logic er);
        case (g)
            0: begin ld = load_a; dst = dst_a; cr = cred_a; wr = wrap_a; er = err_a; end
            1: begin
                ld = load_b[0]; dst = dst_b[63:0]; cr = cred_b[8:0];
                wr = wrap_b[15:0]; er = err_b[0];
            end
            default: begin
                ld = load_b[1]; dst = dst_b[127:64]; cr = cred_b[17:9];
                wr = wrap_b[31:16]; er = err_b[1];
            end
        endcase
    endtask

    always @(negedge rstn) begin
        for (int g = 0; g < 3; g++) model_reset(g);
        sync_cnt = 0;
    end

    // Reset release takes two clock edges to reach the channels.
    always @(posedge clk) begin
        logic [2:0] in;
        cyc++;
        for (int g = 0; g < 3; g++) begin
            in = get_in(g);
            if (!rstn || sync_cnt < 2) model_reset(g);
            else model_step(g, in[2], in[1], in[0]);
        end
        if (!rstn) sync_cnt = 0;
        else if (sync_cnt < 2) sync_cnt++;
    end

    always @(posedge clk) begin
        logic        ld;
        logic [63:0] dst;
        logic [8:0]  cr;
        logic [15:0] wr;
        logic        er;
        #1;
        if (chk_on) begin
            for (int g = 0; g < 3; g++) begin
                get_out(g, ld, dst, cr, wr, er);
                chk($sformatf("load[%0d]", g), 64'(ld), 64'(m_load[g]));
                chk($sformatf("dst[%0d]", g), dst, exp_dst(g));
                chk($sformatf("credits[%0d]", g), 64'(cr), 64'(m_cred[g]));
                chk($sformatf("wrap[%0d]", g), 64'(wr), 64'(m_wrap[g]));
                chk($sformatf("err[%0d]", g), 64'(er), 64'(m_err[g]));
            end
            chk("len_a", 64'(len_a), 64'd4096);
            chk("ctl_a", 64'(ctl_a), 64'd0);
            chk("src_a", src_a, 64'd0);
            chk("len_b", 64'(len_b), {8'd0, 28'd4096, 28'd4096});
            chk("ctl_b", 64'(ctl_b), 64'h5A3C_5A3C);
            chk("src_b", src_b[63:0] | src_b[127:64], 64'd0);
        end
    end

    bit          cap_on = 0;
    logic [63:0] cap_a[$];
    logic [63:0] cap_b0[$];
    logic [63:0] cap_b1[$];
    int          cyc_b0[$];

    always @(posedge clk) begin
        #1;
        if (cap_on) begin
            if (load_a === 1'b1) cap_a.push_back(dst_a);
            if (load_b[0] === 1'b1) begin
                cap_b0.push_back(dst_b[63:0]);
                cyc_b0.push_back(cyc);
            end
            if (load_b[1] === 1'b1) cap_b1.push_back(dst_b[127:64]);
        end
    end

    task automatic wait_load_a(string name);
        bit got;
        got = 0;
        for (int k = 0; k < 100 && !got; k++) begin
            @(posedge clk);
            #1;
            if (load_a === 1'b1) got = 1;
        end
        chk(name, 64'(got), 64'd1);
    endtask

    task automatic pulse_ret_a(int n);
        repeat (n) begin
            ret_a = 1;
            @(negedge clk);
            ret_a = 0;
            @(negedge clk);
        end
    endtask

    initial begin
        int n;
        bit got;
        en_a = 0; rdy_a = 0; ret_a = 0;
        en_b = 0; rdy_b = 0; ret_b = 0;
        for (int g = 0; g < 3; g++) model_reset(g);
        repeat (3) @(negedge clk);
        chk_on = 1;

        chk("rst_load_a", 64'(load_a), 64'd0);
        chk("rst_cred_a", 64'(cred_a), 64'd16);
        chk("rst_dst_a", dst_a, 64'h1_0000_0000);
        chk("rst_dst_b1", dst_b[127:64], 64'h1_0000_4000);
        chk("rst_cred_b0", 64'(cred_b[8:0]), 64'd4);
        rstn = 1;

        // Two-channel ring: ch0 at full rate, ch1 with random ready.
        @(negedge clk);
        en_b = 2'b11; rdy_b[0] = 1; cap_on = 1;
        repeat (60) begin
            @(negedge clk);
            rdy_b[1] = ($urandom_range(0, 1) != 0);
        end
        cap_on = 0;
        chk("b0_nloads", 64'(cap_b0.size()), 64'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap_b0.size()) chk("b0_dst", cap_b0[i], 64'h1_0000_0000 + 64'(i) * 64'h1000);
            if (i > 0 && i < cyc_b0.size()) chk("b0_spacing", 64'(cyc_b0[i] - cyc_b0[i-1]), 64'd2);
        end
        chk("b1_any_load", 64'(cap_b1.size() > 0), 64'd1);
        if (cap_b1.size() > 0) chk("b1_first_dst", cap_b1[0], 64'h1_0000_4000);
        chk("b0_stall_cred", 64'(cred_b[8:0]), 64'd0);

        // Random traffic: first credit-heavy with mostly idle channels, then busy.
        repeat (500) begin
            @(negedge clk);
            en_a  = ($urandom_range(0, 3) == 0);
            rdy_a = ($urandom_range(0, 1) != 0);
            ret_a = ($urandom_range(0, 1) != 0);
            en_b  = 2'($urandom_range(0, 3) == 0 ? $urandom_range(0, 3) : 0);
            rdy_b = {1'($urandom_range(0, 1)), 1'b1};
            ret_b = 2'($urandom_range(0, 3));
        end
        repeat (1000) begin
            @(negedge clk);
            en_a  = ($urandom_range(0, 9) != 0);
            rdy_a = ($urandom_range(0, 3) != 0);
            ret_a = ($urandom_range(0, 3) == 0);
            en_b  = {1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 9) != 0)};
            rdy_b = {1'($urandom_range(0, 1)), 1'b1};
            ret_b = {1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0)};
        end

        @(negedge clk);
        en_a = 0; rdy_a = 0; ret_a = 0; en_b = 0; rdy_b = 0; ret_b = 0;
        rstn = 0;
        repeat (2) @(negedge clk);
        rstn = 1;
        repeat (3) @(negedge clk);

        // Default ring: 16 loads then stall.
        cap_a.delete();
        cap_on = 1;
        en_a = 1; rdy_a = 1;
        repeat (60) @(negedge clk);
        chk("a_nloads16", 64'(cap_a.size()), 64'd16);
        for (int i = 0; i < 16; i++)
            if (i < cap_a.size()) chk("a_dst16", cap_a[i], 64'h1_0000_0000 + 64'(i) * 64'h1000);
        chk("a_stall_cred", 64'(cred_a), 64'd0);

        cap_a.delete();
        pulse_ret_a(3);
        repeat (20) @(negedge clk);
        chk("a_nloads3", 64'(cap_a.size()), 64'd3);
        for (int i = 0; i < 3; i++)
            if (i < cap_a.size()) chk("a_dst3", cap_a[i], 64'h1_0000_0000 + 64'(i) * 64'h1000);
        chk("a_wrap1", 64'(wrap_a), 64'd1);

        rdy_a = 0;
        pulse_ret_a(16);
        chk("a_cred_full", 64'(cred_a), 64'd16);
        chk("a_err_clear", 64'(err_a), 64'd0);
        pulse_ret_a(1);
        chk("a_cred_sat", 64'(cred_a), 64'd16);
        chk("a_err_set", 64'(err_a), 64'd1);

        // Credit return coinciding with a load, ready dropping mid-load.
        rdy_a = 1;
        wait_load_a("a_load_samecyc");
        chk("a_dst_samecyc", dst_a, 64'h1_0000_3000);
        @(negedge clk);
        ret_a = 1; rdy_a = 0;
        @(posedge clk);
        #1;
        chk("a_strobe_one_cycle", 64'(load_a), 64'd0);
        chk("a_cred_samecyc", 64'(cred_a), 64'd16);
        chk("a_err_sticky", 64'(err_a), 64'd1);
        @(negedge clk);
        ret_a = 0;

        // Disable during a load; resume on the following index.
        rdy_a = 1;
        cap_a.delete();
        wait_load_a("a_load_dis");
        chk("a_dst_dis", dst_a, 64'h1_0000_4000);
        @(negedge clk);
        en_a = 0;
        repeat (10) @(negedge clk);
        chk("a_loads_while_dis", 64'(cap_a.size()), 64'd1);
        en_a = 1;
        wait_load_a("a_load_resume");
        chk("a_dst_resume", dst_a, 64'h1_0000_5000);

        // Reset asserted mid-load.
        wait_load_a("a_load_rst");
        chk("a_dst_rst", dst_a, 64'h1_0000_6000);
        @(negedge clk);
        rstn = 0;
        #1;
        chk("a_rst_load_drop", 64'(load_a), 64'd0);
        chk("a_rst_cred", 64'(cred_a), 64'd16);
        chk("a_rst_dst", dst_a, 64'h1_0000_0000);
        repeat (3) @(negedge clk);
        rstn = 1;
        n = 0;
        got = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(posedge clk);
            #1;
            n++;
            if (load_a === 1'b1) got = 1;
        end
        chk("a_load_after_rst", 64'(got), 64'd1);
        chk("a_rel_latency_ge2", 64'(n >= 2), 64'd1);
        chk("a_first_dst_after_rst", dst_a, 64'h1_0000_0000);
        repeat (5) @(negedge clk);
        cap_on = 0;
        chk_on = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
